// File: rtl/game_ctrl.sv
// Guessing-game sequencer: greeting, three timed rounds, win/loss display with timed return.
// Define GAME_HINT_EN to build the above/below hint registers; otherwise hint_hi/hint_lo are tied low.
module game_ctrl #(
    parameter int MAX_TRIES = 7,
    parameter int WIN_HOLD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       next,
    input  logic       sure,
    input  logic [6:0] guess,
    input  logic [6:0] rand_num,
    input  logic       cnt_done,
    output logic [2:0] state,
    output logic       rand_st,
    output logic       cst,
    output logic       dzst,
    output logic [2:0] dz_num,
    output logic       bst,
    output logic       dst,
    output logic [1:0] disp_num,
    output logic [2:0] tries,
    output logic       hint_hi,
    output logic       hint_lo
);

    // state  | meaning
    // IDLE   | game disabled (start low)
    // GREET  | greeting pattern, waiting for next
    // G1..G3 | round n: entry, target load, then guessing
    // WIN    | all three rounds cleared, timed display
    // LOSE   | out of tries or time, timed display
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GREET = 3'd1,
        S_G1    = 3'd2,
        S_G2    = 3'd3,
        S_G3    = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [1:0] PH_ENTRY = 2'd0;
    localparam logic [1:0] PH_LOAD  = 2'd1;
    localparam logic [1:0] PH_PLAY  = 2'd2;

    localparam int          HW        = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(WIN_HOLD - 1);
    localparam logic [2:0]  TRY_LIM   = 3'(MAX_TRIES);

    state_t        cur, nxt;
    logic [1:0]    phase, phase_d;
    logic [6:0]    target;
    logic [HW-1:0] hold, hold_d;
    logic [2:0]    tries_d;
    logic [1:0]    disp_d;
    logic          bst_d;
    logic          in_round;
    logic          hit;

    assign in_round = (cur == S_G1) || (cur == S_G2) || (cur == S_G3);
    assign hit      = (guess == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_IDLE;
            phase    <= PH_ENTRY;
            target   <= '0;
            hold     <= '0;
            tries    <= '0;
            disp_num <= '0;
            bst      <= 1'b0;
        end else begin
            cur      <= nxt;
            phase    <= phase_d;
            hold     <= hold_d;
            tries    <= tries_d;
            disp_num <= disp_d;
            bst      <= bst_d;
            if (in_round && phase == PH_LOAD)
                target <= rand_num;
        end
    end

    always_comb begin
        nxt     = cur;
        phase_d = phase;
        hold_d  = (hold != '0) ? hold - HW'(1) : hold;
        tries_d = tries;
        disp_d  = disp_num;
        bst_d   = 1'b0;
        if (in_round && phase != PH_PLAY)
            phase_d = phase + 2'd1;

        if (!start) begin
            nxt     = S_IDLE;
            phase_d = PH_ENTRY;
            hold_d  = '0;
            tries_d = '0;
            disp_d  = '0;
        end else begin
            case (cur)
                S_IDLE: nxt = S_GREET;
                S_GREET: begin
                    if (next) begin
                        nxt     = S_G1;
                        phase_d = PH_ENTRY;
                        tries_d = '0;
                        disp_d  = '0;
                    end
                end
                S_G1, S_G2, S_G3: begin
                    // Timeout beats a same-cycle guess.
                    if (cnt_done) begin
                        nxt    = S_LOSE;
                        hold_d = HOLD_LOAD;
                        bst_d  = 1'b1;
                    end else if (sure && phase == PH_PLAY) begin
                        if (hit) begin
                            disp_d  = disp_num + 2'd1;
                            bst_d   = 1'b1;
                            phase_d = PH_ENTRY;
                            tries_d = '0;
                            case (cur)
                                S_G1:    nxt = S_G2;
                                S_G2:    nxt = S_G3;
                                default: begin
                                    nxt    = S_WIN;
                                    hold_d = HOLD_LOAD;
                                end
                            endcase
                        end else begin
                            tries_d = (tries < TRY_LIM) ? tries + 3'd1 : tries;
                            if (tries_d == TRY_LIM) begin
                                nxt    = S_LOSE;
                                hold_d = HOLD_LOAD;
                                bst_d  = 1'b1;
                            end
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (hold == '0) begin
                        nxt    = S_GREET;
                        disp_d = '0;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        state   = cur;
        rand_st = in_round && (phase == PH_ENTRY);
        cst     = in_round && (phase != PH_ENTRY);
        dzst    = (cur != S_IDLE);
        dst     = in_round || (cur == S_WIN) || (cur == S_LOSE);
        case (cur)
            S_G1:    dz_num = 3'd1;
            S_G2:    dz_num = 3'd2;
            S_G3:    dz_num = 3'd3;
            S_WIN:   dz_num = 3'd4;
            S_LOSE:  dz_num = 3'd5;
            default: dz_num = 3'd0;
        endcase
    end

`ifdef GAME_HINT_EN
    // A correct guess evaluates to (0,0), which also clears hints for the next round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hint_hi <= 1'b0;
            hint_lo <= 1'b0;
        end else if (!start || cur == S_IDLE || cur == S_GREET) begin
            hint_hi <= 1'b0;
            hint_lo <= 1'b0;
        end else if (in_round && phase == PH_PLAY && sure && !cnt_done) begin
            hint_hi <= (guess > target);
            hint_lo <= (guess < target);
        end
    end
`else
    assign hint_hi = 1'b0;
    assign hint_lo = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play against a cycle model.
module tb_game_ctrl;
    localparam int MT = 3;
    localparam int WH = 6;
`ifdef GAME_HINT_EN
    localparam bit HINT = 1'b1;
`else
    localparam bit HINT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, next, sure, cnt_done;
    logic [6:0] guess, rand_num;

    logic [2:0] state, dz_num, tries;
    logic       rand_st, cst, dzst, bst, dst, hint_hi, hint_lo;
    logic [1:0] disp_num;
    logic [2:0] state2, dz_num2, tries2;
    logic       rand_st2, cst2, dzst2, bst2, dst2, hint_hi2, hint_lo2;
    logic [1:0] disp_num2;
    logic [17:0] act1, act2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_st, m_age, m_target, m_tries, m_disp;
    bit m_hi, m_lo, m_bst;

    always #5 clk = ~clk;

    game_ctrl #(.MAX_TRIES(MT), .WIN_HOLD(WH)) dut (
        .clk(clk), .rst(rst), .start(start), .next(next), .sure(sure), .guess(guess),
        .rand_num(rand_num), .cnt_done(cnt_done), .state(state), .rand_st(rand_st), .cst(cst),
        .dzst(dzst), .dz_num(dz_num), .bst(bst), .dst(dst), .disp_num(disp_num), .tries(tries),
        .hint_hi(hint_hi), .hint_lo(hint_lo));

    game_ctrl #(.MAX_TRIES(2), .WIN_HOLD(WH)) dut2 (
        .clk(clk), .rst(rst), .start(start), .next(next), .sure(sure), .guess(guess),
        .rand_num(rand_num), .cnt_done(cnt_done), .state(state2), .rand_st(rand_st2), .cst(cst2),
        .dzst(dzst2), .dz_num(dz_num2), .bst(bst2), .dst(dst2), .disp_num(disp_num2), .tries(tries2),
        .hint_hi(hint_hi2), .hint_lo(hint_lo2));

    assign act1 = {state, rand_st, cst, dzst, dz_num, bst, dst, disp_num, tries, hint_hi, hint_lo};
    assign act2 = {state2, rand_st2, cst2, dzst2, dz_num2, bst2, dst2, disp_num2, tries2, hint_hi2, hint_lo2};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_target = 0; m_tries = 0; m_disp = 0;
        m_hi = 0; m_lo = 0; m_bst = 0;
    endtask

    function automatic logic [17:0] model_vec();
        logic round;
        round = (m_st >= 2) && (m_st <= 4);
        return {3'(m_st), round && (m_age == 0), round && (m_age >= 1), m_st != 0,
                (m_st == 0) ? 3'd0 : 3'(m_st - 1), m_bst, m_st >= 2, 2'(m_disp), 3'(m_tries),
                HINT & m_hi, HINT & m_lo};
    endfunction

    // One clock of the game rules, applied to the inputs present at the edge.
    task automatic model_step();
        int n_st;
        int old_t;
        n_st  = m_st;
        old_t = m_target;
        m_bst = 0;
        if (!start) begin
            n_st = 0; m_tries = 0; m_disp = 0; m_hi = 0; m_lo = 0;
        end else begin
            case (m_st)
                0: n_st = 1;
                1: begin
                    m_hi = 0; m_lo = 0;
                    if (next) begin n_st = 2; m_tries = 0; m_disp = 0; end
                end
                2, 3, 4: begin
                    if (m_age == 1) m_target = int'(rand_num);
                    if (cnt_done) begin
                        n_st = 6; m_bst = 1;
                    end else if (sure && m_age >= 2) begin
                        if (int'(guess) == old_t) begin
                            m_disp++; m_bst = 1; m_tries = 0; m_hi = 0; m_lo = 0;
                            n_st = (m_st == 4) ? 5 : m_st + 1;
                        end else begin
                            m_hi = int'(guess) > old_t;
                            m_lo = int'(guess) < old_t;
                            if (m_tries < MT) m_tries++;
                            if (m_tries == MT) begin n_st = 6; m_bst = 1; end
                        end
                    end
                end
                default: if (m_age == WH - 1) begin n_st = 1; m_disp = 0; end
            endcase
        end
        m_age = (n_st != m_st) ? 0 : m_age + 1;
        m_st  = n_st;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (act1 !== 18'h0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", act1); end
        n_cmp++; if (act2 !== 18'h0) begin n_bad++; $display("FAIL reset_outputs2 got=%h want=0", act2); end
        rst = 1'b0;
        tick();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_hold got=%0d want=0", state); end
    endtask

    task automatic test_greet();
        start = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL greet_state got=%0d want=1", state); end
        n_cmp++; if ({dzst, dz_num, cst, dst} !== 6'b100000) begin
            n_bad++; $display("FAIL greet_outs got=%b want=100000", {dzst, dz_num, cst, dst}); end
        sure = 1'b1; guess = 7'd5;
        tick();
        sure = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL greet_sure_ignored got=%0d want=1", state); end
    endtask

    task automatic test_first_round();
        rand_num = 7'd42;
        next = 1'b1;
        tick();
        next = 1'b0;
        n_cmp++; if ({state, rand_st, cst, tries} !== {3'd2, 1'b1, 1'b0, 3'd0}) begin
            n_bad++; $display("FAIL g1_entry got=%b want=%b", {state, rand_st, cst, tries}, {3'd2, 1'b1, 1'b0, 3'd0}); end
        sure = 1'b1; guess = 7'd42;
        tick();
        n_cmp++; if ({state, disp_num, bst, rand_st, cst} !== {3'd2, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL g1_entry_sure_ignored got=%b want=%b", {state, disp_num, bst, rand_st, cst}, {3'd2, 2'd0, 1'b0, 1'b0, 1'b1}); end
        tick();
        n_cmp++; if ({state, disp_num, bst} !== {3'd2, 2'd0, 1'b0}) begin
            n_bad++; $display("FAIL g1_load_sure_ignored got=%b want=%b", {state, disp_num, bst}, {3'd2, 2'd0, 1'b0}); end
        tick();
        sure = 1'b0;
        n_cmp++; if ({state, bst, disp_num, rand_st, cst} !== {3'd3, 1'b1, 2'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL g1_hit got=%b want=%b", {state, bst, disp_num, rand_st, cst}, {3'd3, 1'b1, 2'd1, 1'b1, 1'b0}); end
        n_cmp++; if ({state2, disp_num2} !== {3'd3, 2'd1}) begin
            n_bad++; $display("FAIL g1_hit2 got=%b want=%b", {state2, disp_num2}, {3'd3, 2'd1}); end
        tick();
        n_cmp++; if ({bst, rand_st} !== 2'b00) begin n_bad++; $display("FAIL pulse_width got=%b want=00", {bst, rand_st}); end
    endtask

    task automatic test_hints_and_loss();
        tick();
        sure = 1'b1; guess = 7'd50;
        tick();
        n_cmp++; if ({state, tries, hint_hi, hint_lo} !== {3'd3, 3'd1, HINT, 1'b0}) begin
            n_bad++; $display("FAIL hint_high got=%b want=%b", {state, tries, hint_hi, hint_lo}, {3'd3, 3'd1, HINT, 1'b0}); end
        guess = 7'd10;
        tick();
        sure = 1'b0;
        n_cmp++; if ({state, tries, hint_hi, hint_lo} !== {3'd3, 3'd2, 1'b0, HINT}) begin
            n_bad++; $display("FAIL hint_low got=%b want=%b", {state, tries, hint_hi, hint_lo}, {3'd3, 3'd2, 1'b0, HINT}); end
        n_cmp++; if ({state2, dz_num2, bst2, disp_num2, tries2} !== {3'd6, 3'd5, 1'b1, 2'd1, 3'd2}) begin
            n_bad++; $display("FAIL tries_loss got=%b want=%b", {state2, dz_num2, bst2, disp_num2, tries2}, {3'd6, 3'd5, 1'b1, 2'd1, 3'd2}); end
        sure = 1'b1; guess = 7'd42; cnt_done = 1'b1;
        tick();
        sure = 1'b0; cnt_done = 1'b0;
        n_cmp++; if ({state, disp_num, dz_num, bst} !== {3'd6, 2'd1, 3'd5, 1'b1}) begin
            n_bad++; $display("FAIL timeout_wins got=%b want=%b", {state, disp_num, dz_num, bst}, {3'd6, 2'd1, 3'd5, 1'b1}); end
        n_cmp++; if ({state2, bst2} !== {3'd6, 1'b0}) begin
            n_bad++; $display("FAIL lose_bst_once got=%b want=%b", {state2, bst2}, {3'd6, 1'b0}); end
        repeat (WH - 2) tick();
        n_cmp++; if ({state2, disp_num2} !== {3'd6, 2'd1}) begin
            n_bad++; $display("FAIL lose_hold_end got=%b want=%b", {state2, disp_num2}, {3'd6, 2'd1}); end
        tick();
        n_cmp++; if ({state2, disp_num2} !== {3'd1, 2'd0}) begin
            n_bad++; $display("FAIL lose_to_greet2 got=%b want=%b", {state2, disp_num2}, {3'd1, 2'd0}); end
        n_cmp++; if (state !== 3'd6) begin n_bad++; $display("FAIL lose_hold got=%0d want=6", state); end
        tick();
        n_cmp++; if ({state, disp_num} !== {3'd1, 2'd0}) begin
            n_bad++; $display("FAIL lose_to_greet got=%b want=%b", {state, disp_num}, {3'd1, 2'd0}); end
    endtask

    task automatic hit_round();
        int v;
        v = $urandom_range(0, 127);
        rand_num = 7'(v);
        tick();
        tick();
        guess = 7'(v); sure = 1'b1;
        tick();
        sure = 1'b0;
    endtask

    task automatic test_three_rounds();
        next = 1'b1;
        tick();
        next = 1'b0;
        for (int r = 0; r < 3; r++) begin
            hit_round();
            n_cmp++; if (state !== 3'(r == 2 ? 5 : 3 + r)) begin
                n_bad++; $display("FAIL round%0d_advance got=%0d want=%0d", r + 1, state, (r == 2) ? 5 : 3 + r); end
        end
        n_cmp++; if ({state, dz_num, disp_num, bst} !== {3'd5, 3'd4, 2'd3, 1'b1}) begin
            n_bad++; $display("FAIL win got=%b want=%b", {state, dz_num, disp_num, bst}, {3'd5, 3'd4, 2'd3, 1'b1}); end
        repeat (WH - 1) tick();
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL win_hold got=%0d want=5", state); end
        tick();
        n_cmp++; if ({state, disp_num} !== {3'd1, 2'd0}) begin
            n_bad++; $display("FAIL win_to_greet got=%b want=%b", {state, disp_num}, {3'd1, 2'd0}); end
    endtask

    task automatic test_start_drop();
        next = 1'b1;
        tick();
        next = 1'b0;
        hit_round();
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if (act1 !== 18'h0) begin n_bad++; $display("FAIL start_drop got=%h want=0", act1); end
        start = 1'b1;
    endtask

    task automatic test_async_reset();
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        hit_round();
        hit_round();
        tick();
        tick();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL reach_g3 got=%0d want=4", state); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (act1 !== 18'h0) begin n_bad++; $display("FAIL async_reset got=%h want=0", act1); end
        n_cmp++; if (act2 !== 18'h0) begin n_bad++; $display("FAIL async_reset2 got=%h want=0", act2); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [17:0] exp_v;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            exp_v = model_vec();
            n_cmp++; if (act1 !== exp_v) begin
                n_bad++; $display("FAIL rand_cyc%0d got=%h want=%h", i, act1, exp_v); end
            start    = ($urandom_range(0, 299) != 0);
            next     = ($urandom_range(0, 7) == 0);
            sure     = ($urandom_range(0, 2) == 0);
            cnt_done = ($urandom_range(0, 79) == 0);
            rand_num = 7'($urandom_range(0, 127));
            guess    = ($urandom_range(0, 2) == 0) ? 7'(m_target) : 7'($urandom_range(0, 127));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        start = 1'b1; next = 1'b0; sure = 1'b0; cnt_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; next = 1'b0; sure = 1'b0; cnt_done = 1'b0;
        guess = 7'd0; rand_num = 7'd0;
        test_reset();
        test_greet();
        test_first_round();
        test_hints_and_loss();
        test_three_rounds();
        test_start_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
